wb_ram_arbiter: RTL and testbench
=================================

// Module: wb_ram_arbiter
// PURPOSE
//  Two-master Wishbone classic arbiter sharing the single-port wb_ram between
//  the CPU instruction port (m0) and data port (m1) inside naive_soc.
//  Registered grant; the owner holds the bus for its whole cyc; the selected
//  master's signals are muxed to the slave and ack/rdata are routed back.
//  Optional watchdog aborts a hung transfer with err.
// PARAMETERS
//  AW         32   address width
//  DW         32   data width (SW = DW/8 byte selects)
//  ROUND_ROBIN 0   0: m1 (data) has fixed priority; 1: alternate on contention
//  TIMEOUT    64   watchdog limit in cycles (used only with WB_ARB_TIMEOUT_EN)
// PORTS
//  clk                       in   1      system clock
//  reset                     in   1      synchronous, active-high reset
//  m0_addr / m1_addr         in   AW     master byte address
//  m0_wdata / m1_wdata       in   DW     master write data
//  m0_sel / m1_sel           in   SW     master byte selects
//  m0_we,cyc,stb / m1_...    in   1 each master write enable, cycle, strobe
//  m0_rdata / m1_rdata       out  DW     read data (slave rdata, broadcast)
//  m0_ack / m1_ack           out  1      ack, gated by grant
//  m0_err / m1_err           out  1      watchdog abort, gated by grant
//  s_addr,s_wdata,s_sel,s_we out  AW,DW,SW,1  muxed from owner
//  s_cyc / s_stb             out  1      owner cyc/stb, 0 when idle
//  s_rdata                   in   DW     slave read data
//  s_ack                     in   1      slave ack
// BEHAVIOUR
//  - FSM: IDLE, OWN0, OWN1 (registered). Reset -> IDLE; last_owner <= m0.
//  - Outputs in IDLE: s_cyc=s_stb=0, s_we=0, s_sel=0, addr/wdata=0;
//    m*_ack=m*_err=0. These hold during and immediately after reset.
//  - Arbitrate when state is IDLE, or OWNx with mx_cyc=0 (release):
//    req = {m1_cyc, m0_cyc}; none -> IDLE; one -> that master;
//    both, ROUND_ROBIN=0 -> OWN1; both, ROUND_ROBIN=1 -> master != last_owner.
//    Release and re-grant take one edge: OWN0 with m0_cyc=0 and m1_cyc=1 goes
//    straight to OWN1 (no idle bubble). Owner keeps the bus while its cyc=1.
//  - Latency: request in cycle N -> grant visible and s_cyc asserted in N+1.
//  - Mux is combinational from the registered state: s_* = owner's signals;
//    s_cyc = owner_cyc & owner_active, s_stb = owner_stb.
//  - mX_ack = s_ack & (state==OWNX); non-owner never sees ack or err.
//  - last_owner updates on every transition into OWN0/OWN1.
//  - Owner dropping cyc while s_ack pending: ack ignored (protocol violation
//    by master; arbiter does not stall). Simultaneous release/request handled
//    by the single arbitration rule above.
//  - Reset mid-transfer: FSM to IDLE next edge; s_cyc deasserted; no ack out.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined: 8-bit-min counter clears on grant change and on
//    s_ack, increments each cycle while s_cyc&s_stb; at count==TIMEOUT-1 the
//    owner gets a 1-cycle mX_err, and the FSM forces the slave s_cyc low for
//    that cycle and returns to IDLE (last_owner updated as normal).
//  Not defined: no counter; m0_err=m1_err=0 constant.
// STRUCTURE
//  - Package wb_arb_pkg: state encoding consts (ST_IDLE=2'd0, ST_OWN0=2'd1,
//    ST_OWN1=2'd2), master index consts M_INST=0, M_DATA=1.
//  - One sub-module: wb_arb_pick (pure combinational: req[1:0], last_owner,
//    ROUND_ROBIN -> grant_valid, grant_idx). Mux and FSM stay in top.
// TESTING (bench uses wb_ram behavioural model: ack 2 cycles after req)
//  1 reset held 3 cycles with both cyc=1 -> s_cyc=0, acks=0; release ->
//    OWN1 next edge, s_addr=m1_addr.
//  2 m0 alone reads addr 0x0000_0010 -> s_cyc 1 cycle after m0_cyc,
//    m0_ack with m0_rdata=model[4]; m1_ack stays 0.
//  3 both request continuously, ROUND_ROBIN=0 -> m1 served every time m0
//    waits; ROUND_ROBIN=1 -> grants alternate 1,0,1,0 with no idle bubble.
//  4 m1 writes 0xDEADBEEF sel=4'b0011 to 0x20 while m0 waits -> model word 8
//    low half = 0xBEEF, then m0 granted on edge of m1_cyc drop.
//  5 WB_ARB_TIMEOUT_EN, TIMEOUT=16, slave never acks -> m0_err pulse exactly
//    at cycle 16 of s_stb, s_cyc low, FSM IDLE; without macro err stays 0.
//  6 reset asserted while OWN0 read outstanding -> no m0_ack, IDLE next edge.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared encodings for the two-master Wishbone RAM arbiter.
// Provides the FSM state type and the master index constants.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    // Master indices: m0 is the CPU instruction port, m1 the data port.
    localparam logic M_INST = 1'b0;
    localparam logic M_DATA = 1'b1;

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational grant picker for two requesters.
// Chooses fixed data-port priority or alternation on contention.
module wb_arb_pick
    import wb_arb_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic [1:0] req_i,
    input  logic       last_owner_i,
    output logic       grant_valid_o,
    output logic       grant_idx_o
);

    // NOTE: every output of an always_comb gets a default first so no path
    // through the block leaves it unassigned and infers a latch.
    always_comb begin
        grant_valid_o = |req_i;
        grant_idx_o   = M_INST;
        case (req_i)
            2'b01:   grant_idx_o = M_INST;
            2'b10:   grant_idx_o = M_DATA;
            2'b11:   grant_idx_o = ROUND_ROBIN ? ~last_owner_i : M_DATA;
            default: grant_idx_o = M_INST;
        endcase
    end

endmodule

// File: rtl/wb_ram_arbiter.sv
// Two-master Wishbone classic arbiter in front of the single-port wb_ram.
// Define WB_ARB_TIMEOUT_EN to enable the hung-transfer watchdog (err abort).
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter bit ROUND_ROBIN = 1'b0,
    parameter int TIMEOUT     = 64,
    localparam int SW         = DW / 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [SW-1:0] m0_sel,
    input  logic          m0_we,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_ack,
    output logic          m0_err,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    input  logic [SW-1:0] m1_sel,
    input  logic          m1_we,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    output logic [SW-1:0] s_sel,
    output logic          s_we,
    output logic          s_cyc,
    output logic          s_stb,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ack
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic       grant_valid, grant_idx;
    logic       own0, own1;
    logic       owner_cyc, owner_stb;
    logic       timeout_hit;

    wb_arb_pick #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_pick (
        .req_i        ({m1_cyc, m0_cyc}),
        .last_owner_i (last_q),
        .grant_valid_o(grant_valid),
        .grant_idx_o  (grant_idx)
    );

    // Reset gates ownership immediately so the slave sees an idle bus
    // during reset, not only after the next edge.
    assign own0      = (state_q == ST_OWN0) && !reset;
    assign own1      = (state_q == ST_OWN1) && !reset;
    assign owner_cyc = (own0 && m0_cyc) || (own1 && m1_cyc);
    assign owner_stb = (own0 && m0_stb) || (own1 && m1_stb);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (timeout_hit) begin
            state_d = ST_IDLE;
        end else if (!((state_q == ST_OWN0 && m0_cyc) ||
                       (state_q == ST_OWN1 && m1_cyc))) begin
            if (grant_valid) begin
                state_d = (grant_idx == M_DATA) ? ST_OWN1 : ST_OWN0;
                last_d  = grant_idx;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= M_INST;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT) > 8) ? $clog2(TIMEOUT) : 8;

    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    // The count restarts whenever the bus changes hands or the slave answers.
    assign timeout_hit = owner_cyc && owner_stb && (wd_cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_d != state_q || s_ack) begin
            wd_cnt_d = '0;
        end else if (owner_cyc && owner_stb) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign m0_err = timeout_hit && own0;
    assign m1_err = timeout_hit && own1;
`else
    assign timeout_hit = 1'b0;
    assign m0_err      = 1'b0;
    assign m1_err      = 1'b0;
`endif

    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        if (own0) begin
            s_addr  = m0_addr;
            s_wdata = m0_wdata;
            s_sel   = m0_sel;
            s_we    = m0_we;
            s_cyc   = m0_cyc && !timeout_hit;
            s_stb   = m0_stb;
        end else if (own1) begin
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_sel   = m1_sel;
            s_we    = m1_we;
            s_cyc   = m1_cyc && !timeout_hit;
            s_stb   = m1_stb;
        end
    end

    assign m0_ack   = s_ack && own0;
    assign m1_ack   = s_ack && own1;
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Self-checking bench: fixed-priority and round-robin arbiters side by side,
// each with its own behavioural wb_ram slave (ack two cycles after request).
module tb_wb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic reset;

    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic [SW-1:0] m0_sel, m1_sel;
    logic          m0_we, m0_cyc, m0_stb;
    logic          m1_we, m1_cyc, m1_stb;

    logic [1:0][DW-1:0] m0_rdata_w, m1_rdata_w, s_wdata_w, s_rdata_w;
    logic [1:0][AW-1:0] s_addr_w;
    logic [1:0][SW-1:0] s_sel_w;
    logic [1:0]         m0_ack_w, m1_ack_w, m0_err_w, m1_err_w;
    logic [1:0]         s_we_w, s_cyc_w, s_stb_w, s_ack_w;

    logic          model_en, no_ack, tb_ack;
    logic [DW-1:0] tb_rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_ram_arbiter #(.AW(AW), .DW(DW), .ROUND_ROBIN(1'b0), .TIMEOUT(16)) dut_rr0 (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(m0_rdata_w[0]),
        .m0_ack(m0_ack_w[0]), .m0_err(m0_err_w[0]),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(m1_rdata_w[0]),
        .m1_ack(m1_ack_w[0]), .m1_err(m1_err_w[0]),
        .s_addr(s_addr_w[0]), .s_wdata(s_wdata_w[0]), .s_sel(s_sel_w[0]),
        .s_we(s_we_w[0]), .s_cyc(s_cyc_w[0]), .s_stb(s_stb_w[0]),
        .s_rdata(s_rdata_w[0]), .s_ack(s_ack_w[0])
    );

    wb_ram_arbiter #(.AW(AW), .DW(DW), .ROUND_ROBIN(1'b1), .TIMEOUT(16)) dut_rr1 (
        .clk(clk), .reset(reset),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_sel(m0_sel), .m0_we(m0_we),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_rdata(m0_rdata_w[1]),
        .m0_ack(m0_ack_w[1]), .m0_err(m0_err_w[1]),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_sel(m1_sel), .m1_we(m1_we),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_rdata(m1_rdata_w[1]),
        .m1_ack(m1_ack_w[1]), .m1_err(m1_err_w[1]),
        .s_addr(s_addr_w[1]), .s_wdata(s_wdata_w[1]), .s_sel(s_sel_w[1]),
        .s_we(s_we_w[1]), .s_cyc(s_cyc_w[1]), .s_stb(s_stb_w[1]),
        .s_rdata(s_rdata_w[1]), .s_ack(s_ack_w[1])
    );

    // Behavioural wb_ram per arbiter; in table mode s_ack/s_rdata come from the bench.
    for (genvar g = 0; g < 2; g++) begin : g_slave
        logic [DW-1:0] mem [16];
        logic          ack_q;
        logic [7:0]    wait_q;
        logic [DW-1:0] rdata_q;
        logic [3:0]    idx;

        assign idx          = s_addr_w[g][5:2];
        assign s_ack_w[g]   = model_en ? ack_q : tb_ack;
        assign s_rdata_w[g] = model_en ? rdata_q : tb_rdata;

        always @(posedge clk) begin
            if (reset) begin
                ack_q   <= 1'b0;
                wait_q  <= 8'd0;
                rdata_q <= '0;
                for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | i;
            end else if (!model_en || !(s_cyc_w[g] && s_stb_w[g]) || ack_q) begin
                ack_q  <= 1'b0;
                wait_q <= 8'd0;
            end else if (wait_q == 8'd1 && !no_ack) begin
                ack_q  <= 1'b1;
                wait_q <= 8'd0;
                if (s_we_w[g]) begin
                    for (int b = 0; b < SW; b++)
                        if (s_sel_w[g][b]) mem[idx][8*b +: 8] <= s_wdata_w[g][8*b +: 8];
                end else begin
                    rdata_q <= mem[idx];
                end
            end else begin
                wait_q <= wait_q + 8'd1;
            end
        end
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Table vector: master cyc/stb, reset and slave ack in; expected owner per
    // arbiter out (0 idle, 1 m0, 2 m1).
    typedef struct {
        logic       rst;
        logic       c0;
        logic       c1;
        logic       ack;
        logic [1:0] own_rr0;
        logic [1:0] own_rr1;
    } vec_t;

    function automatic vec_t mk(input int r, input int c0, input int c1, input int a,
                                input int o0, input int o1);
        vec_t v;
        v.rst     = r[0];
        v.c0      = c0[0];
        v.c1      = c1[0];
        v.ack     = a[0];
        v.own_rr0 = o0[1:0];
        v.own_rr1 = o1[1:0];
        return v;
    endfunction

    function automatic logic [138:0] exp_bus(input logic [1:0] own, input logic ack,
                                             input logic [DW-1:0] rd);
        logic [74:0] b;
        case (own)
            2'd1:    b = {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h1111_1111, ack, 1'b0, 2'b00};
            2'd2:    b = {1'b1, 1'b1, 1'b1, 4'h3, 32'h0000_0200, 32'h2222_2222, 1'b0, ack, 2'b00};
            default: b = '0;
        endcase
        return {b, rd, rd};
    endfunction

    function automatic logic [138:0] act_bus(input int g);
        return {s_cyc_w[g], s_stb_w[g], s_we_w[g], s_sel_w[g], s_addr_w[g], s_wdata_w[g],
                m0_ack_w[g], m1_ack_w[g], m0_err_w[g], m1_err_w[g],
                m0_rdata_w[g], m1_rdata_w[g]};
    endfunction

    // Waits on arbiter 0 for the chosen master's ack; reports the cycles taken
    // and whether the other master ever saw an ack meanwhile.
    task automatic wait_ack0(input bit m1, output bit got, output int cycles, output bit other);
        got    = 1'b0;
        cycles = 0;
        other  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (m1 ? m0_ack_w[0] : m1_ack_w[0]) other = 1'b1;
            if (m1 ? m1_ack_w[0] : m0_ack_w[0]) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t vecs [21];
        bit   got, other;
        int   cycles;

        vecs[0]  = mk(1, 1, 1, 0, 0, 0);
        vecs[1]  = mk(1, 1, 1, 0, 0, 0);
        vecs[2]  = mk(1, 1, 1, 0, 0, 0);
        vecs[3]  = mk(0, 1, 1, 0, 2, 2);
        vecs[4]  = mk(0, 1, 1, 1, 2, 2);
        vecs[5]  = mk(0, 1, 0, 0, 1, 1);
        vecs[6]  = mk(0, 0, 1, 0, 2, 2);
        vecs[7]  = mk(0, 1, 0, 0, 1, 1);
        vecs[8]  = mk(0, 1, 1, 0, 1, 1);
        vecs[9]  = mk(0, 1, 1, 1, 1, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0);
        vecs[11] = mk(0, 0, 1, 0, 2, 2);
        vecs[12] = mk(0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 1, 0, 2, 1);
        vecs[14] = mk(0, 1, 1, 1, 2, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 1, 1, 0, 2, 2);
        vecs[17] = mk(0, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 1, 1, 0, 2, 1);
        vecs[19] = mk(0, 1, 0, 0, 1, 1);
        vecs[20] = mk(0, 0, 0, 1, 0, 0);

        reset    = 1'b1;
        model_en = 1'b0;
        no_ack   = 1'b0;
        tb_ack   = 1'b0;
        tb_rdata = '0;
        m0_addr  = 32'h0000_0100; m0_wdata = 32'h1111_1111; m0_sel = 4'hF; m0_we = 1'b0;
        m1_addr  = 32'h0000_0200; m1_wdata = 32'h2222_2222; m1_sel = 4'h3; m1_we = 1'b1;
        m0_cyc   = 1'b1; m0_stb = 1'b1;
        m1_cyc   = 1'b1; m1_stb = 1'b1;

        #1;
        check("reset before first edge s_cyc", {s_cyc_w, m0_ack_w, m1_ack_w}, 6'b0);

        // Table-driven arbitration, handover and ack routing.
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            m0_cyc   = vecs[i].c0; m0_stb = vecs[i].c0;
            m1_cyc   = vecs[i].c1; m1_stb = vecs[i].c1;
            tb_ack   = vecs[i].ack;
            tb_rdata = 32'h5A00_0000 | i;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d rr0", i), act_bus(0), exp_bus(vecs[i].own_rr0, vecs[i].ack, tb_rdata));
            check($sformatf("vec%0d rr1", i), act_bus(1), exp_bus(vecs[i].own_rr1, vecs[i].ack, tb_rdata));
        end

        // m0 alone reads 0x10 from the RAM model.
        @(negedge clk);
        tb_ack = 1'b0; model_en = 1'b1;
        m0_addr = 32'h0000_0010; m0_we = 1'b0; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
        @(posedge clk);
        #1;
        check("t2 grant latency s_cyc", s_cyc_w[0], 1'b1);
        check("t2 s_addr", s_addr_w[0], 32'h0000_0010);
        wait_ack0(1'b0, got, cycles, other);
        check("t2 m0_ack seen", got, 1'b1);
        check("t2 ack cycles after grant", cycles, 2);
        check("t2 m0_rdata", m0_rdata_w[0], 32'hC0DE_0004);
        check("t2 no m1_ack", other, 1'b0);
        @(negedge clk);
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(posedge clk);
        #1;
        check("t2 idle after release", {s_cyc_w[0], s_stb_w[0]}, 2'b00);

        // m1 byte-masked write while m0 waits; m0 takes over on m1_cyc drop.
        @(negedge clk);
        m1_addr = 32'h0000_0020; m1_wdata = 32'hDEAD_BEEF; m1_sel = 4'b0011; m1_we = 1'b1;
        m1_cyc = 1'b1; m1_stb = 1'b1;
        @(negedge clk);
        m0_addr = 32'h0000_0020; m0_we = 1'b0; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
        check("t4 m1 owns bus", {s_we_w[0], s_sel_w[0]}, 5'b1_0011);
        wait_ack0(1'b1, got, cycles, other);
        check("t4 m1_ack seen", got, 1'b1);
        check("t4 no m0_ack while waiting", other, 1'b0);
        @(negedge clk);
        m1_cyc = 1'b0; m1_stb = 1'b0;
        @(posedge clk);
        #1;
        check("t4 m0 granted on m1 drop", {s_cyc_w[0], s_we_w[0], s_sel_w[0]}, 6'b1_0_1111);
        check("t4 model word 8", g_slave[0].mem[8], 32'hC0DE_BEEF);
        wait_ack0(1'b0, got, cycles, other);
        check("t4 m0 readback ack", got, 1'b1);
        check("t4 m0 readback data", m0_rdata_w[0], 32'hC0DE_BEEF);
        @(negedge clk);
        m0_cyc = 1'b0; m0_stb = 1'b0;

        // Slave never acks.
        @(negedge clk);
        no_ack = 1'b1;
        m0_addr = 32'h0000_0000; m0_cyc = 1'b1; m0_stb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
        begin
            int stb_n   = 0;
            bit err_hit = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (s_stb_w[0]) stb_n++;
                if (m0_err_w[0]) begin
                    err_hit = 1'b1;
                    check("t5 err at stb cycle", stb_n, 16);
                    check("t5 s_cyc low on err", s_cyc_w[0], 1'b0);
                    check("t5 no m1_err", m1_err_w[0], 1'b0);
                    break;
                end
            end
            check("t5 m0_err pulse seen", err_hit, 1'b1);
            @(posedge clk);
            #1;
            check("t5 idle after abort", {s_cyc_w[0], s_stb_w[0], m0_err_w[0]}, 3'b000);
        end
`else
        begin
            int err_n = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (m0_err_w != 2'b00 || m1_err_w != 2'b00) err_n++;
            end
            check("t5 err stays 0 without watchdog", err_n, 0);
            check("t5 bus still held", s_cyc_w[0], 1'b1);
        end
`endif
        @(negedge clk);
        m0_cyc = 1'b0; m0_stb = 1'b0; no_ack = 1'b0;

        // Reset while an OWN0 read is outstanding.
        @(negedge clk);
        m0_addr = 32'h0000_0010; m0_cyc = 1'b1; m0_stb = 1'b1;
        @(posedge clk);
        #1;
        check("t6 m0 owns", s_cyc_w[0], 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t6 s_cyc dropped in reset", s_cyc_w[0], 1'b0);
        @(posedge clk);
        #1;
        check("t6 no ack after reset edge", {m0_ack_w[0], s_cyc_w[0]}, 2'b00);
        @(negedge clk);
        reset = 1'b0;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        @(posedge clk);
        #1;
        check("t6 idle after reset", {s_cyc_w[0], s_stb_w[0], m0_ack_w[0], s_addr_w[0]}, 35'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
